// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (start + DATA_BITS LSB-first + optional parity + STOP_BITS).
// Latency: rx_valid rises 2 + HALF + (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT + 1 clk_in cycles after the start edge.
// Backpressure: one holding register; a good frame ending while it is full and not drained is dropped (overrun_err).
// Ports: clk_in/rst_in (async, active-high); data_in serial line (idle high);
//        rx_data/rx_valid/rx_ready payload handshake; framing_err/overrun_err/parity_err one-cycle pulses;
//        busy high whenever the receiver FSM is not idle.
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit (sense PARITY_ODD) between data and stop.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DLAST_C = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] SLAST_C = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 sync1_q, sync2_q;
  logic                 line;
  logic                 frame_done;
  logic                 framing_hit, frame_good, load;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_q, overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD_C = (PARITY_ODD != 0);
  logic                 par_bad_q, par_bad_d;
  logic                 parity_hit;
  logic                 parity_q;
`endif

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end
  assign line = sync2_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      stop_bad_q <= stop_bad_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_bad_d = stop_bad_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!line) state_d = S_START;
      end
      // Re-check the line at mid start bit; a high line here was a glitch.
      S_START: begin
        if (clk_cnt_q == HALF_C) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = line ? S_IDLE : S_DATA;
        end
      end
      // clk_cnt restarts at mid start bit, so wrapping at LAST_C lands mid-bit.
      S_DATA: begin
        if (clk_cnt_q == LAST_C) begin
          clk_cnt_d = '0;
          shift_d   = {line, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DLAST_C) begin
            bit_cnt_d  = '0;
            stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
            state_d    = S_PARITY;
`else
            state_d    = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == LAST_C) begin
          clk_cnt_d = '0;
          par_bad_d = ((^shift_q) ^ line) != ODD_C;
          state_d   = S_STOP;
        end
      end
`endif
      // Leave on the last stop sample so a back-to-back start bit is not missed.
      S_STOP: begin
        if (clk_cnt_q == LAST_C) begin
          clk_cnt_d = '0;
          if (!line) stop_bad_d = 1'b1;
          if (bit_cnt_q == SLAST_C) begin
            bit_cnt_d  = '0;
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Frame commit: the current stop sample is folded in directly, earlier ones via stop_bad_q.
  always_comb begin
    framing_hit = frame_done & (stop_bad_q | ~line);
`ifdef UART_RX_PARITY_EN
    parity_hit  = frame_done & par_bad_q;
    frame_good  = frame_done & ~framing_hit & ~parity_hit;
`else
    frame_good  = frame_done & ~framing_hit;
`endif
    // A same-cycle accept frees the holding register, so the new frame may load.
    load       = frame_good & (~rx_valid_q | rx_ready);
    rx_data_d  = load ? shift_q : rx_data_q;
    rx_valid_d = load | (rx_valid_q & ~rx_ready);
    overrun_d  = frame_good & rx_valid_q & ~rx_ready;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      framing_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      framing_q  <= framing_hit;
      overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_q   <= parity_hit;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_q;
`else
  assign parity_err  = 1'b0;
`endif
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed plus random frames for uart_rx_param against a frame-level reference model.
// The bit period is shortened to 32 clocks so the run stays short; latency follows the same formula.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam int DB = 7, SB = 2, PAR = 1;
`else
  localparam int DB = 8, SB = 1, PAR = 0;
`endif
  localparam int CPB   = 32;
  localparam int ODD   = 0;
  localparam int HALF  = (CPB - 1) / 2;
  localparam int LAT   = 2 + HALF + (DB + PAR + SB) * CPB + 1;
  localparam logic [8:0] MASK = 9'((1 << DB) - 1);

  logic          clk_in = 1'b0;
  logic          rst_in, data_in, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, framing_err, overrun_err, parity_err, busy;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(ODD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun_err(overrun_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Observed behaviour, collected away from the active edge.
  int         n_fe = 0, n_or = 0, n_pe = 0, n_unstable = 0, rise_cyc = 0;
  logic       prev_vld = 1'b0, prev_acc = 1'b0;
  logic [DB-1:0] prev_dat = '0;
  logic [8:0] got_q[$];

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (framing_err) n_fe++;
      if (overrun_err) n_or++;
      if (parity_err)  n_pe++;
      if (rx_valid && !prev_vld) rise_cyc = cyc;
      if (prev_vld && !prev_acc && rx_data !== prev_dat) n_unstable++;
      if (rx_valid && rx_ready) got_q.push_back(9'(rx_data));
    end
    prev_vld = rx_valid;
    prev_acc = rx_valid && rx_ready;
    prev_dat = rx_data;
  end

  // Frame-level reference model: one holding slot, counts of expected error pulses.
  int         m_fe = 0, m_or = 0, m_pe = 0;
  logic       m_hold_vld = 1'b0;
  logic [8:0] m_hold = '0;
  logic [8:0] m_acc_q[$];

  function automatic logic good_par(input logic [8:0] d);
    return logic'(($countones(d) + ODD) % 2);
  endfunction

  function automatic logic model_frame(input logic [8:0] d, input logic pbit, input logic sbad, input logic rdy);
    logic perr;
    perr = (PAR != 0) && ((($countones(d) + int'(pbit)) % 2) != ODD);
    if (sbad) m_fe++;
    if (perr) m_pe++;
    if (sbad || perr) return 1'b0;
    if (m_hold_vld && !rdy) begin
      m_or++;
    end else begin
      if (m_hold_vld) begin
        m_acc_q.push_back(m_hold);
        m_hold_vld = 1'b0;
      end
      if (rdy) m_acc_q.push_back(d);
      else begin
        m_hold_vld = 1'b1;
        m_hold     = d;
      end
    end
    return 1'b1;
  endfunction

  function automatic void model_release();
    if (m_hold_vld) m_acc_q.push_back(m_hold);
    m_hold_vld = 1'b0;
  endfunction

  int n_cmp = 0, n_bad = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus runs in the phase just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input logic pbit, input logic sbad);
    start_cyc = cyc + 1;  // first edge that samples the start bit
    data_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      data_in = d[i];
      idle(CPB);
    end
    if (PAR != 0) begin
      data_in = pbit;
      idle(CPB);
    end
    for (int i = 0; i < SB; i++) begin
      data_in = ~sbad;
      idle(CPB);
    end
    data_in = 1'b1;
  endtask

  task automatic chk_lat(input string tag);
    chk(tag, rise_cyc - start_cyc, LAT);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/framing"}, n_fe, m_fe);
    chk({tag, "/overrun"}, n_or, m_or);
    chk({tag, "/parity"}, n_pe, m_pe);
    chk({tag, "/accepted"}, got_q.size(), m_acc_q.size());
    while (got_q.size() > 0 && m_acc_q.size() > 0)
      chk({tag, "/data"}, got_q.pop_front(), m_acc_q.pop_front());
    got_q.delete();
    m_acc_q.delete();
  endtask

  initial begin
    logic [8:0] d;
    logic       pbit, sbad, ok;

    rst_in = 1'b1; data_in = 1'b1; rx_ready = 1'b1;
    #3;
    chk("reset/rx_data", 32'(rx_data), 0);
    chk("reset/rx_valid", rx_valid, 0);
    chk("reset/errors", {framing_err, overrun_err, parity_err}, 0);
    chk("reset/busy", busy, 0);
    idle(3);
    rst_in = 1'b0;
    idle(4);

    // 1: single frame, immediate consumer.
    d = 9'hA5 & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b1);
    send_frame(d, good_par(d), 1'b0);
    chk("t1/latency", rise_cyc - start_cyc, LAT);
    idle(CPB);
    check_model("t1");

    // 2: back-to-back frames with no idle gap.
    d = 9'h3C & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b1);
    send_frame(d, good_par(d), 1'b0);
    chk_lat("t2/latency0");
    d = 9'hC3 & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b1);
    send_frame(d, good_par(d), 1'b0);
    chk_lat("t2/latency1");
    idle(CPB);
    check_model("t2");

    // 3: stalled consumer, second frame overruns, then drain.
    rx_ready = 1'b0;
    d = 9'h11 & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b0);
    send_frame(d, good_par(d), 1'b0);
    chk_lat("t3/latency");
    d = 9'h22 & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b0);
    send_frame(d, good_par(d), 1'b0);
    idle(CPB);
    chk("t3/held_valid", rx_valid, 1);
    chk("t3/held_data", 32'(rx_data), 32'(9'h11 & MASK));
    chk("t3/overrun", n_or, m_or);
    rx_ready = 1'b1;
    model_release();
    idle(2);
    chk("t3/valid_cleared", rx_valid, 0);
    check_model("t3");

    // 4: bad stop bit, then a good frame.
    d = 9'h55 & MASK;
    ok = model_frame(d, good_par(d), 1'b1, 1'b1);
    send_frame(d, good_par(d), 1'b1);
    idle(2 * CPB);
    chk("t4/no_valid", rx_valid, 0);
    chk("t4/framing", n_fe, m_fe);
    d = 9'h0F & MASK;
    ok = model_frame(d, good_par(d), 1'b0, 1'b1);
    send_frame(d, good_par(d), 1'b0);
    chk_lat("t4/latency");
    idle(CPB);
    check_model("t4");

    // 5a: short low glitch on an idle line.
    data_in = 1'b0;
    idle(HALF - 4);
    chk("t5/glitch_busy", busy, 1);
    data_in = 1'b1;
    idle(CPB);
    chk("t5/glitch_idle", busy, 0);
    chk("t5/glitch_valid", rx_valid, 0);
    check_model("t5a");

    // 5b: reset in the middle of a 0xFF frame.
    data_in = 1'b0;
    idle(CPB);
    data_in = 1'b1;
    idle(3 * CPB);
    chk("t5/midframe_busy", busy, 1);
    rst_in = 1'b1;
    #2;
    chk("t5/rst_rx_data", 32'(rx_data), 0);
    chk("t5/rst_outputs", {rx_valid, framing_err, overrun_err, parity_err, busy}, 0);
    idle(2);
    rst_in = 1'b0;
    idle((DB + PAR + SB + 2) * CPB);
    chk("t5/rst_no_valid", rx_valid, 0);
    check_model("t5b");

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad.
    d = 9'h41 & MASK;
    ok = model_frame(d, 1'b0, 1'b0, 1'b1);
    send_frame(d, 1'b0, 1'b0);
    chk_lat("t6/latency");
    ok = model_frame(d, 1'b1, 1'b0, 1'b1);
    send_frame(d, 1'b1, 1'b0);
    idle(CPB);
    chk("t6/no_valid", rx_valid, 0);
    check_model("t6");
`endif

    // Random frames: random payload, occasional bad stop or bad parity, random gaps.
    for (int k = 0; k < 40; k++) begin
      d    = 9'($urandom) & MASK;
      sbad = ($urandom_range(0, 3) == 0);
      pbit = good_par(d);
      if (PAR != 0 && $urandom_range(0, 3) == 0) pbit = ~pbit;
      ok = model_frame(d, pbit, sbad, 1'b1);
      send_frame(d, pbit, sbad);
      if (ok) chk_lat($sformatf("rand%0d/latency", k));
      if (sbad) idle(2 * CPB);
      else idle($urandom_range(0, CPB));
    end
    idle(CPB);
    check_model("rand");
    chk("rx_data_stable", n_unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It replaces the fixed 8N1 display-driving receiver with a reusable core: configurable baud divisor, data width and stop-bit count, plus a valid/ready output, framing-error and overrun reporting. It sits between the board RX pin and any byte consumer (seven-segment driver, FIFO, command decoder).

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per bit (100 MHz / 115200); minimum 4.
DATA_BITS, 8, payload bits per frame, range 5..9, LSB first.
STOP_BITS, 1, stop bits checked, 1 or 2.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
clk_in  in  1  system clock; all logic on rising edge.
rst_in  in  1  asynchronous, active-high reset.
data_in  in  1  asynchronous serial line, idle high.
rx_data  out  DATA_BITS  received payload, held while rx_valid=1.
rx_valid  out  1  payload available.
rx_ready  in  1  consumer accepts the payload when rx_valid&&rx_ready.
framing_err  out  1  one-cycle pulse: a checked stop bit sampled 0.
overrun_err  out  1  one-cycle pulse: a good frame was lost because the holding register was full.
parity_err  out  1  one-cycle pulse; tied 0 without UART_RX_PARITY_EN.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: FSM=IDLE, counters=0, sync flops=1, rx_data=0, rx_valid=0, all error pulses=0, busy=0. Asserting rst_in mid-frame aborts the frame immediately with no flags.
- data_in passes through a 2-flop synchroniser reset to 1. All references to "line" below mean the synchronised value.
- Clock counter clk_cnt is $clog2(CLKS_PER_BIT) bits wide. Bit counter bit_cnt is $clog2(DATA_BITS+1) bits wide.
- IDLE: when line=0, go to START with clk_cnt=0.
- START: count to HALF=(CLKS_PER_BIT-1)/2.
  - Line still 0 at HALF: go to DATA, clk_cnt=0, bit_cnt=0.
  - Line 1 at HALF: glitch; return to IDLE with no flag.
- DATA: sample when clk_cnt==CLKS_PER_BIT-1, which is mid-bit. Shift in LSB first. After DATA_BITS samples go to PARITY if enabled, otherwise to STOP.
- PARITY (macro only): sample one bit. Error condition is (XOR of payload XOR sampled bit) != PARITY_ODD. Record it and go to STOP.
- STOP: sample STOP_BITS bits, one period apart.
  - On the last stop sample, return to IDLE in the same cycle. No wait for the end of the stop bit, so back-to-back frames are received.
  - Any stop sample = 0: framing_err pulses on the cycle after the last stop sample, and the payload is discarded.
  - Parity error: parity_err pulses on the same cycle, and the payload is discarded.
- Frame commit, on the cycle after the last stop sample, for good frames only:
  - If rx_valid=0, or rx_valid&&rx_ready on that same cycle: load rx_data and set rx_valid=1.
  - Otherwise keep the old data and pulse overrun_err.
- Handshake: rx_valid clears on the cycle after rx_valid&&rx_ready unless a new commit occurs that same cycle. Commit wins: rx_valid stays 1 with the new data. rx_data must not change while rx_valid=1 except on that accepted-and-reloaded cycle.
- Latency: rx_valid rises 2 (sync) + HALF + (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT + 1 cycles after the start edge on data_in. P=1 with the macro, 0 without.
- Line stuck low (break): the frame ends with framing_err. FSM returns to IDLE and, because line=0, immediately re-enters START. It continues flagging framing_err once per frame time until the line returns high. No lockup.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state present, one parity bit expected between data and stop, parity_err driven as above.
- Undefined: no PARITY state, frame = start + DATA_BITS + STOP_BITS, parity_err constantly 0, PARITY_ODD unused.

Test Plan:
1. Defaults, rx_ready=1: send 0xA5 (8N1, 868 clk/bit) -> one rx_valid pulse with rx_data=0xA5 at the computed latency; framing_err=overrun_err=0.
2. Two back-to-back frames 0x3C,0xC3 with no idle gap, rx_ready=1 -> rx_valid twice, data 0x3C then 0xC3, no errors.
3. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at the end of the second frame; raising rx_ready then clears rx_valid.
4. Send 0x55 with the stop bit driven 0 -> framing_err one-cycle pulse, rx_valid stays 0; the next good 0x0F is received correctly.
5. 300-cycle low glitch on the idle line -> FSM returns to IDLE after HALF, no outputs change; assert rst_in mid-frame of 0xFF -> all outputs 0, no rx_valid.
6. With UART_RX_PARITY_EN, PARITY_ODD=0, DATA_BITS=7, STOP_BITS=2: send 0x41 with parity 0 -> rx_data=0x41; resend with parity 1 -> parity_err pulse, rx_valid stays 0.
